// File: rtl/tdp_ram_pkg.sv
// Shared types and helpers for the byte-enabled true dual-port RAM.
// Read-during-write ordering constants, clear FSM states, lane merge.
package tdp_ram_pkg;

  localparam int RDW_READ_FIRST  = 0;
  localparam int RDW_WRITE_FIRST = 1;

  // Widest word the merge helper handles; callers cast to their width.
  localparam int MAX_W  = 256;
  localparam int MAX_BE = MAX_W / 8;

  typedef enum logic {
    ST_CLEAR,
    ST_RUN
  } state_t;

  // Replace each byte lane of old_w whose enable is set with new_w.
  function automatic logic [MAX_W-1:0] merge_bytes(
    input logic [MAX_W-1:0]  old_w,
    input logic [MAX_W-1:0]  new_w,
    input logic [MAX_BE-1:0] be
  );
    logic [MAX_W-1:0] m;
    m = old_w;
    for (int i = 0; i < MAX_BE; i++) begin
      if (be[i]) m[i*8 +: 8] = new_w[i*8 +: 8];
    end
    return m;
  endfunction

endpackage

// File: rtl/tdp_ram_clear_ctrl.sv
// Post-reset clear sequencer for tdp_ram_be.
// Walks every address once, then hands the array to the ports.
module tdp_ram_clear_ctrl
  import tdp_ram_pkg::*;
#(
  parameter int ADDR_WIDTH     = 4,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] clear_addr,
  output logic                  clear_we
);

  state_t                state;
  logic [ADDR_WIDTH-1:0] cnt;

  // Clear FSM: one word per cycle, busy drops with the last write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
      busy  <= (CLEAR_ON_RESET != 0);
      cnt   <= '0;
    end else begin
      unique case (state)
        ST_CLEAR: begin
          cnt <= cnt + 1'b1;
          if (&cnt) begin
            state <= ST_RUN;
            busy  <= 1'b0;
          end
        end
        ST_RUN: begin
          state <= ST_RUN;
        end
        default: begin
          state <= ST_RUN;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign clear_addr = cnt;
  assign clear_we   = (state == ST_CLEAR);

endmodule

// File: rtl/tdp_ram_be.sv
// True dual-port RAM with byte enables, registered reads,
// selectable read-during-write order and collision flagging.
module tdp_ram_be
  import tdp_ram_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 4,
  parameter int RDW_MODE       = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en_a,
  input  logic                    wr_en_a,
  input  logic [DATA_WIDTH/8-1:0] be_a,
  input  logic [ADDR_WIDTH-1:0]   addr_a,
  input  logic [DATA_WIDTH-1:0]   data_in_a,
  output logic [DATA_WIDTH-1:0]   data_out_a,
  output logic                    valid_a,
  input  logic                    en_b,
  input  logic                    wr_en_b,
  input  logic [DATA_WIDTH/8-1:0] be_b,
  input  logic [ADDR_WIDTH-1:0]   addr_b,
  input  logic [DATA_WIDTH-1:0]   data_in_b,
  output logic [DATA_WIDTH-1:0]   data_out_b,
  output logic                    valid_b,
  output logic                    busy,
  output logic                    collision
);

  localparam int DEPTH    = 2 ** ADDR_WIDTH;
  localparam bit WR_FIRST = (RDW_MODE == RDW_WRITE_FIRST);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  clear_we;
  logic [ADDR_WIDTH-1:0] clear_addr;

  logic                  act_a, act_b;
  logic                  wr_a, wr_b, same;
  logic [DATA_WIDTH-1:0] old_a, old_b;
  logic [DATA_WIDTH-1:0] new_b, base_a, new_a, fin_b;

  tdp_ram_clear_ctrl #(
    .ADDR_WIDTH     (ADDR_WIDTH),
    .CLEAR_ON_RESET (CLEAR_ON_RESET)
  ) u_clear (
    .clk        (clk),
    .rst        (rst),
    .busy       (busy),
    .clear_addr (clear_addr),
    .clear_we   (clear_we)
  );

  assign act_a = en_a & ~busy;
  assign act_b = en_b & ~busy;
  assign wr_a  = act_a & wr_en_a;
  assign wr_b  = act_b & wr_en_b;
  assign same  = (addr_a == addr_b);

  assign old_a = mem[addr_a];
  assign old_b = mem[addr_b];

  // B merges first so that A's lanes land on top when both hit one word.
  assign new_b  = DATA_WIDTH'(merge_bytes(MAX_W'(old_b),
                    MAX_W'(data_in_b), MAX_BE'(be_b)));
  assign base_a = (wr_b && same) ? new_b : old_a;
  assign new_a  = DATA_WIDTH'(merge_bytes(MAX_W'(base_a),
                    MAX_W'(data_in_a), MAX_BE'(be_a)));
  assign fin_b  = (wr_a && same) ? new_a : new_b;

  // Array update: clear sweep, else port writes with A owning overlaps.
  always_ff @(posedge clk) begin
    if (clear_we) begin
      mem[clear_addr] <= '0;
    end else begin
      if (wr_b && !(wr_a && same)) mem[addr_b] <= new_b;
      if (wr_a) mem[addr_a] <= new_a;
    end
  end

  // Registered read ports, valids and the collision pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out_a <= '0;
      data_out_b <= '0;
      valid_a    <= 1'b0;
      valid_b    <= 1'b0;
      collision  <= 1'b0;
    end else begin
      valid_a   <= act_a;
      valid_b   <= act_b;
      collision <= act_a & act_b & same & (wr_en_a | wr_en_b);
      if (act_a) data_out_a <= (wr_a && WR_FIRST) ? new_a : old_a;
      if (act_b) data_out_b <= (wr_b && WR_FIRST) ? fin_b : old_b;
    end
  end

endmodule

// File: tb/tb_tdp_ram_be.sv
// Bench for tdp_ram_be: read-first and write-first instances share
// stimulus and are checked against a word-array reference model.
module tb_tdp_ram_be;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en_a = 1'b0, wr_en_a = 1'b0;
  logic [1:0]  be_a = '0;
  logic [3:0]  addr_a = '0;
  logic [15:0] data_in_a = '0;
  logic        en_b = 1'b0, wr_en_b = 1'b0;
  logic [1:0]  be_b = '0;
  logic [3:0]  addr_b = '0;
  logic [15:0] data_in_b = '0;

  logic [15:0] dout_a [2];
  logic [15:0] dout_b [2];
  logic        va [2];
  logic        vb [2];
  logic        bsy [2];
  logic        col [2];

  int n_checks = 0;
  int n_err = 0;

  logic [15:0] m_mem [16];
  logic [15:0] e_out_a [2];
  logic [15:0] e_out_b [2];
  logic        e_va, e_vb, e_col, e_busy;
  int          clear_left;

  always #5 clk = ~clk;

  for (genvar k = 0; k < 2; k++) begin : g_dut
    tdp_ram_be #(
      .DATA_WIDTH     (16),
      .ADDR_WIDTH     (4),
      .RDW_MODE       (k),
      .CLEAR_ON_RESET (1)
    ) dut (
      .clk        (clk),
      .rst        (rst),
      .en_a       (en_a),
      .wr_en_a    (wr_en_a),
      .be_a       (be_a),
      .addr_a     (addr_a),
      .data_in_a  (data_in_a),
      .data_out_a (dout_a[k]),
      .valid_a    (va[k]),
      .en_b       (en_b),
      .wr_en_b    (wr_en_b),
      .be_b       (be_b),
      .addr_b     (addr_b),
      .data_in_b  (data_in_b),
      .data_out_b (dout_b[k]),
      .valid_b    (vb[k]),
      .busy       (bsy[k]),
      .collision  (col[k])
    );
  end

  task automatic set_a(input logic e, input logic w, input logic [1:0] be,
                       input logic [3:0] ad, input logic [15:0] d);
    en_a = e; wr_en_a = w; be_a = be; addr_a = ad; data_in_a = d;
  endtask

  task automatic set_b(input logic e, input logic w, input logic [1:0] be,
                       input logic [3:0] ad, input logic [15:0] d);
    en_b = e; wr_en_b = w; be_b = be; addr_b = ad; data_in_b = d;
  endtask

  task automatic idle();
    set_a(0, 0, 2'b00, 4'd0, 16'h0);
    set_b(0, 0, 2'b00, 4'd0, 16'h0);
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      e_out_a[k] = '0;
      e_out_b[k] = '0;
    end
    e_va = 0; e_vb = 0; e_col = 0; e_busy = 1;
    clear_left = 16;
  endtask

  // Advance the reference model by one clock, then the DUTs.
  task automatic step();
    logic [15:0] oa, ob;
    if (clear_left > 0) begin
      m_mem[16 - clear_left] = '0;
      clear_left--;
      e_va = 0; e_vb = 0; e_col = 0;
    end else begin
      oa = m_mem[addr_a];
      ob = m_mem[addr_b];
      e_col = en_a && en_b && (addr_a == addr_b) && (wr_en_a || wr_en_b);
      if (en_b && wr_en_b)
        for (int i = 0; i < 2; i++)
          if (be_b[i]) m_mem[addr_b][i*8 +: 8] = data_in_b[i*8 +: 8];
      if (en_a && wr_en_a)
        for (int i = 0; i < 2; i++)
          if (be_a[i]) m_mem[addr_a][i*8 +: 8] = data_in_a[i*8 +: 8];
      e_va = en_a;
      e_vb = en_b;
      if (en_a) begin
        e_out_a[0] = oa;
        e_out_a[1] = wr_en_a ? m_mem[addr_a] : oa;
      end
      if (en_b) begin
        e_out_b[0] = ob;
        e_out_b[1] = wr_en_b ? m_mem[addr_b] : ob;
      end
    end
    e_busy = (clear_left > 0);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle();
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    model_reset();
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (bsy[k] !== 1'b1 || va[k] !== 1'b0 || vb[k] !== 1'b0 ||
          col[k] !== 1'b0 || dout_a[k] !== 16'h0 || dout_b[k] !== 16'h0) begin
        n_err++;
        $display("FAIL reset dut%0d: busy=%b va=%b vb=%b col=%b da=%h db=%h want 1 0 0 0 0 0",
                 k, bsy[k], va[k], vb[k], col[k], dout_a[k], dout_b[k]);
      end
    end
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_clear();
    int n = 0;
    while (bsy[0] === 1'b1 && n < 40) begin
      step();
      n++;
    end
    n_checks++;
    if (n != 16 || bsy[1] !== 1'b0 || e_busy !== 1'b0) begin
      n_err++;
      $display("FAIL clear_len: busy cycles %0d busy1=%b want 16 and 0", n, bsy[1]);
    end
    for (int i = 0; i < 16; i++) begin
      set_a(1, 0, 2'b00, 4'(i), 16'h0);
      step();
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if (dout_a[k] !== 16'h0000 || va[k] !== 1'b1) begin
          n_err++;
          $display("FAIL clear_read dut%0d addr %0d: got %h v=%b want 0000 v=1",
                   k, i, dout_a[k], va[k]);
        end
      end
    end
    idle();
  endtask

  task automatic test_dual_write_read();
    for (int i = 0; i < 16; i++) begin
      set_a(1, 1, 2'b11, 4'(i), 16'(i + 1));
      step();
    end
    set_a(0, 0, 2'b00, 4'd0, 16'h0);
    for (int i = 0; i < 16; i++) begin
      set_b(1, 0, 2'b00, 4'(i), 16'h0);
      step();
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if (dout_b[k] !== 16'(i + 1) || vb[k] !== 1'b1 || va[k] !== 1'b0) begin
          n_err++;
          $display("FAIL dual_read dut%0d addr %0d: got %h vb=%b va=%b want %h 1 0",
                   k, i, dout_b[k], vb[k], va[k], 16'(i + 1));
        end
      end
    end
    idle();
  endtask

  task automatic test_rdw();
    set_a(1, 1, 2'b11, 4'd3, 16'h0055);
    step();
    set_a(1, 1, 2'b11, 4'd3, 16'h00AA);
    step();
    n_checks++;
    if (dout_a[0] !== 16'h0055 || dout_a[0] !== e_out_a[0]) begin
      n_err++;
      $display("FAIL rdw_read_first: got %h want 0055", dout_a[0]);
    end
    n_checks++;
    if (dout_a[1] !== 16'h00AA || dout_a[1] !== e_out_a[1]) begin
      n_err++;
      $display("FAIL rdw_write_first: got %h want 00aa", dout_a[1]);
    end
    set_a(1, 0, 2'b00, 4'd3, 16'h0);
    step();
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (dout_a[k] !== 16'h00AA) begin
        n_err++;
        $display("FAIL rdw_followup dut%0d: got %h want 00aa", k, dout_a[k]);
      end
    end
    idle();
  endtask

  task automatic test_collision();
    set_a(1, 1, 2'b11, 4'd5, 16'h0000);
    step();
    set_a(1, 1, 2'b01, 4'd5, 16'h1111);
    set_b(1, 1, 2'b11, 4'd5, 16'h2222);
    step();
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (col[k] !== 1'b1 || e_col !== 1'b1) begin
        n_err++;
        $display("FAIL coll_ww dut%0d: collision=%b want 1", k, col[k]);
      end
    end
    idle();
    step();
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (col[k] !== 1'b0) begin
        n_err++;
        $display("FAIL coll_pulse dut%0d: collision=%b want 0", k, col[k]);
      end
    end
    set_a(1, 0, 2'b00, 4'd5, 16'h0);
    step();
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (dout_a[k] !== 16'h2211) begin
        n_err++;
        $display("FAIL coll_merge dut%0d: got %h want 2211", k, dout_a[k]);
      end
    end
    set_a(1, 1, 2'b11, 4'd7, 16'hCAFE);
    set_b(1, 0, 2'b00, 4'd7, 16'h0);
    step();
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (dout_b[k] !== 16'h0008 || col[k] !== 1'b1) begin
        n_err++;
        $display("FAIL coll_rw dut%0d: got %h col=%b want 0008 col=1",
                 k, dout_b[k], col[k]);
      end
    end
    idle();
  endtask

  task automatic test_disabled();
    set_a(1, 0, 2'b00, 4'd9, 16'h0);
    step();
    set_a(0, 1, 2'b11, 4'd9, 16'hFFFF);
    step();
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (va[k] !== 1'b0 || dout_a[k] !== 16'h000A) begin
        n_err++;
        $display("FAIL disabled dut%0d: va=%b da=%h want 0 000a", k, va[k], dout_a[k]);
      end
    end
    set_b(1, 0, 2'b00, 4'd9, 16'h0);
    set_a(0, 0, 2'b00, 4'd0, 16'h0);
    step();
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (dout_b[k] !== 16'h000A) begin
        n_err++;
        $display("FAIL disabled_mem dut%0d: got %h want 000a", k, dout_b[k]);
      end
    end
    idle();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      set_a(1'($urandom_range(0, 3) != 0), 1'($urandom), 2'($urandom),
            4'($urandom), 16'($urandom));
      set_b(1'($urandom_range(0, 3) != 0), 1'($urandom), 2'($urandom),
            4'($urandom), 16'($urandom));
      if ($urandom_range(0, 3) == 0) addr_b = addr_a;
      step();
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if (dout_a[k] !== e_out_a[k] || dout_b[k] !== e_out_b[k] ||
            va[k] !== e_va || vb[k] !== e_vb || col[k] !== e_col) begin
          n_err++;
          $display("FAIL random dut%0d cyc %0d: da=%h db=%h va=%b vb=%b col=%b want %h %h %b %b %b",
                   k, c, dout_a[k], dout_b[k], va[k], vb[k], col[k],
                   e_out_a[k], e_out_b[k], e_va, e_vb, e_col);
        end
      end
    end
    idle();
  endtask

  task automatic test_reset_mid_clear();
    int n = 0;
    idle();
    rst = 1'b1;
    #1;
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (8) step();
    n_checks++;
    if (bsy[0] !== 1'b1 || bsy[1] !== 1'b1) begin
      n_err++;
      $display("FAIL midclear_busy: busy=%b%b want 11", bsy[1], bsy[0]);
    end
    rst = 1'b1;
    #1;
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    set_a(1, 1, 2'b11, 4'd2, 16'hBEEF);
    while (bsy[0] === 1'b1 && n < 40) begin
      step();
      n++;
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if (va[k] !== 1'b0) begin
          n_err++;
          $display("FAIL busy_valid dut%0d: va=%b want 0", k, va[k]);
        end
      end
    end
    n_checks++;
    if (n != 16 || bsy[1] !== 1'b0) begin
      n_err++;
      $display("FAIL midclear_len: busy cycles %0d want 16", n);
    end
    set_a(1, 0, 2'b00, 4'd2, 16'h0);
    step();
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (dout_a[k] !== 16'h0000 || dout_a[k] !== e_out_a[k]) begin
        n_err++;
        $display("FAIL busy_write dut%0d: got %h want 0000", k, dout_a[k]);
      end
    end
    idle();
  endtask

  initial begin
    #2;
    test_reset();
    test_clear();
    test_dual_write_read();
    test_rdw();
    test_collision();
    test_disabled();
    test_random();
    test_reset_mid_clear();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/tdp_ram_be.md
Name: tdp_ram_be

Overview:
- Parametrised true dual-port RAM; successor to the team's single-write-port dual-port RAM.
- Both ports A and B can independently read or write, with byte enables.
- Reads are registered and flagged by a valid output; read-during-write ordering is selectable.
- Same-address collisions are detected and flagged.
- An optional clear sequence zeroes the array after reset.
- Sits between datapath masters and shared buffer storage.

Parameters:
- DATA_WIDTH, 8, word width in bits; must be a multiple of 8.
- ADDR_WIDTH, 4, address width; DEPTH = 2**ADDR_WIDTH words, derived as a localparam.
- RDW_MODE, 0, same-port read-during-write ordering: 0 = read-first (old data), 1 = write-first (new data).
- CLEAR_ON_RESET, 1, when 1, zero every word after reset; when 0, the array is not initialised.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- en_a  in  1  port A access enable
- wr_en_a  in  1  port A write (1) / read (0); qualified by en_a
- be_a  in  DATA_WIDTH/8  port A byte enables for writes
- addr_a  in  ADDR_WIDTH  port A address
- data_in_a  in  DATA_WIDTH  port A write data
- data_out_a  out  DATA_WIDTH  port A registered read data
- valid_a  out  1  data_out_a updated this cycle
- en_b, wr_en_b, be_b, addr_b, data_in_b, data_out_b, valid_b: same as port A, for port B
- busy  out  1  clear sequence in progress; requests ignored
- collision  out  1  registered pulse, same-address conflict last cycle

Behaviour:
- Reset (async, rst=1):
  - data_out_a, data_out_b = 0; valid_a, valid_b = 0; collision = 0.
  - busy = CLEAR_ON_RESET; clear counter = 0.
  - Array contents are unchanged by reset itself.
- FSM states CLEAR and RUN:
  - Reset enters CLEAR if CLEAR_ON_RESET=1, else RUN.
  - CLEAR writes 0 to mem[counter] each cycle and increments the counter.
  - After writing word DEPTH-1: go to RUN; busy drops on the same edge. Clear takes exactly DEPTH cycles after rst deasserts.
  - Reset asserted mid-clear restarts the counter at 0.
  - In CLEAR, all port requests are ignored: no writes, valid stays 0, data_out holds.
- RUN, per port, latency 1:
  - Read (en=1, wr_en=0): next edge data_out = mem[addr]; valid=1.
  - Write (en=1, wr_en=1): for each byte i with be[i]=1, mem[addr] byte i = data_in byte i. Next edge valid=1, and data_out = pre-write word (RDW_MODE=0) or post-merge word (RDW_MODE=1).
  - Write with be all zero: no array change; still returns data and asserts valid.
  - en=0: valid=0; data_out holds its last value.
- Collisions (both en=1, addr_a==addr_b, at least one writing):
  - collision=1 on the next edge, for one cycle per conflicting cycle.
  - Both writing: byte lanes enabled on A take A's data; lanes enabled only on B take B's data. Port A wins overlaps.
  - Read on one port, write on the other: the reader gets the old word, regardless of RDW_MODE.
  - Both reading the same address: not a collision; both return the word.
- Address wrap: none needed; every ADDR_WIDTH value is a valid address.
- No combinational path from inputs to outputs.

Decomposition:
- Package tdp_ram_pkg:
  - RDW_READ_FIRST = 0 and RDW_WRITE_FIRST = 1 constants.
  - State enum {ST_CLEAR, ST_RUN}.
  - Byte-mask merge function: old word, new word, be -> merged word.
- Sub-module tdp_ram_clear_ctrl: owns the CLEAR/RUN FSM and counter; drives busy, clear address and clear write enable.
- Top level: owns the array, the port logic and collision arbitration.

Test Plan:
- Clear: release rst with CLEAR_ON_RESET=1 -> busy=1 for exactly 16 cycles. Then read addr 0..15 on A -> each returns 0x00 with valid_a=1, one cycle after request.
- Dual write/read: A writes i+1 to addr i (i=0..15). Then B reads 0..15 -> data_out_b = 0x01..0x10 in order, 1-cycle latency; A idle gives valid_a=0.
- Read-during-write, same port: mem[3]=0x55; A writes 0xAA to addr 3. RDW_MODE=0 -> data_out_a=0x55; RDW_MODE=1 -> 0xAA. A following read returns 0xAA.
- Collision: DATA_WIDTH=16, mem[5]=0x0000. A writes 0x1111 with be=2'b01; B writes 0x2222 with be=2'b11, same cycle -> mem[5]=0x2211 and collision=1 for one cycle. B read while A writes addr 7 -> B gets the old word, collision=1.
- Reset mid-clear: assert rst at clear cycle 8, release -> busy stays high a full 16 further cycles. A write attempted during busy does not land; a read afterwards returns 0.
- Disabled ports: en_a=0 with wr_en_a=1 -> no array change, valid_a=0, data_out_a holds its previous value.
